// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the coordinate type.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL       = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL       = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int SYNC_DLY_DEF  = 2;

endpackage

// File: rtl/sync_delay.sv
// DEPTH-stage shift pipeline for an active-low sync strobe; advances on pix_ce, resets to 1.
module sync_delay #(
  parameter int DEPTH = 2
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic pix_ce,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sr <= '1;
    end else if (pix_ce) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, blanking decode and delayed sync generation.
// Optional 16-bit frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int SYNC_DLY  = SYNC_DLY_DEF
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        pix_ce,
  output coord_t      DrawX,
  output coord_t      DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] frame_count,
`endif
  output logic        frame_start
);

  localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic line_end;
  logic frame_end;
  logic hs_n;
  logic vs_n;

  assign line_end  = (DrawX == H_LAST);
  assign frame_end = line_end && (DrawY == V_LAST);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        if (line_end) begin
          DrawX <= '0;
          if (frame_end) begin
            DrawY       <= '0;
            frame_start <= 1'b1;
          end else begin
            DrawY <= DrawY + 10'd1;
          end
        end else begin
          DrawX <= DrawX + 10'd1;
        end
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (pix_ce && frame_end) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

  // blank is high in the visible area, aligned with the registered counters
  assign blank = (DrawX < H_VIS) && (DrawY < V_VIS);
  assign hs_n  = !((DrawX >= HS_START) && (DrawX <= HS_END));
  assign vs_n  = !((DrawY >= VS_START) && (DrawY <= VS_END));

  // Delay matches the downstream pixel data latency; zero depth is a wire.
  generate
    if (SYNC_DLY == 0) begin : g_sync_direct
      assign hs = hs_n;
      assign vs = vs_n;
    end else begin : g_sync_pipe
      sync_delay #(.DEPTH(SYNC_DLY)) u_hs_dly (
        .vga_clk (vga_clk),
        .reset   (reset),
        .pix_ce  (pix_ce),
        .d       (hs_n),
        .q       (hs)
      );
      sync_delay #(.DEPTH(SYNC_DLY)) u_vs_dly (
        .vga_clk (vga_clk),
        .reset   (reset),
        .pix_ce  (pix_ce),
        .d       (vs_n),
        .q       (vs)
      );
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing, two shrunk-raster instances for frame timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic pix_ce;

  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic       b0, b1, b2, hs0, hs1, hs2, vs0, vs1, vs2, fs0, fs1, fs2;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc0, fc1, fc2;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n       = 0;
  int fs0_cnt = 0;
  int fs1_cnt = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(.SYNC_DLY(2)) d0 (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(x0), .DrawY(y0), .blank(b0), .hs(hs0), .vs(vs0),
`ifdef VGA_FRAME_CNT_EN
    .frame_count(fc0),
`endif
    .frame_start(fs0)
  );

  // 16x12 raster: hs low X 10..12, vs low Y 8..9
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_DLY(2)
  ) d1 (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(x1), .DrawY(y1), .blank(b1), .hs(hs1), .vs(vs1),
`ifdef VGA_FRAME_CNT_EN
    .frame_count(fc1),
`endif
    .frame_start(fs1)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_DLY(0)
  ) d2 (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(x2), .DrawY(y2), .blank(b2), .hs(hs2), .vs(vs2),
`ifdef VGA_FRAME_CNT_EN
    .frame_count(fc2),
`endif
    .frame_start(fs2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      n++;
      if (fs0) fs0_cnt++;
      if (fs1) fs1_cnt++;
    end
  endtask

  task automatic adv_to(input int target);
    step(target - n);
  endtask

  task automatic do_reset(input logic ce_after);
    reset = 1'b1;
    step(3);
    reset  = 1'b0;
    pix_ce = ce_after;
    n = 0;
    fs0_cnt = 0;
    fs1_cnt = 0;
  endtask

  initial begin
    int first_low;
    int lows;
    int moved;
    int first_x;
    logic [9:0] prev_x;
    logic [9:0] x_mid, y_mid;

    reset  = 1'b1;
    pix_ce = 1'b1;
    step(3);
    chk("rst_x", x0, 0);
    chk("rst_y", y0, 0);
    chk("rst_blank", b0, 1);
    chk("rst_hs", hs0, 1);
    chk("rst_vs", vs0, 1);
    chk("rst_fs", fs0, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("rst_fc", fc0, 0);
`endif

    // Phase A: full-size line timing
    do_reset(1'b1);
    step(1);
    chk("a_x1", x0, 1);
    chk("a_y1", y0, 0);
    adv_to(639);
    chk("a_blank_639", b0, 1);
    adv_to(640);
    chk("a_blank_640_0", b0, 0);
    adv_to(655);
    first_low = -1;
    lows = 0;
    repeat (110) begin
      step(1);
      if (!hs0) begin
        lows++;
        if (first_low < 0) first_low = n;
      end
    end
    chk("a_hs_fall", first_low, 658);
    chk("a_hs_width", lows, 96);
    adv_to(799);
    chk("a_x799", x0, 799);
    chk("a_y799", y0, 0);
    adv_to(800);
    chk("a_wrap_x", x0, 0);
    chk("a_wrap_y", y0, 1);
    chk("a_vs_hi", vs0, 1);

    // Phase B: asynchronous reset mid-line while hs is low
    adv_to(1500);
    chk("b_pre_x", x0, 700);
    chk("b_pre_hs", hs0, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("b_async_x", x0, 0);
    chk("b_async_y", y0, 0);
    chk("b_async_hs", hs0, 1);
    chk("b_async_blank", b0, 1);
    @(posedge clk);
    #1;
    step(2);
    chk("b_hold_x", x0, 0);
    chk("b_hold_fs", fs0, 0);
    reset = 1'b0;
    n = 0;
    fs0_cnt = 0;
    fs1_cnt = 0;
    step(3);
    chk("b_resume_x", x0, 3);
    chk("b_resume_y", y0, 0);
    chk("b_no_fs", fs0_cnt + fs1_cnt, 0);

    // Phase C: shrunk raster frame timing
    do_reset(1'b1);
    adv_to(8);
    chk("c_blank_8_0", b1, 0);
    adv_to(9);
    chk("c_d0_hs_9", hs2, 1);
    adv_to(10);
    chk("c_d0_hs_10", hs2, 0);
    chk("c_d2_hs_10", hs1, 1);
    adv_to(12);
    chk("c_d2_hs_12", hs1, 0);
    adv_to(15);
    chk("c_d2_hs_15", hs1, 1);
    adv_to(87);
    chk("c_blank_7_5", b1, 1);
    adv_to(96);
    chk("c_blank_0_6", b1, 0);
    adv_to(127);
    chk("c_d0_vs_127", vs2, 1);
    adv_to(128);
    chk("c_d0_vs_128", vs2, 0);
    adv_to(129);
    chk("c_d2_vs_129", vs1, 1);
    adv_to(130);
    chk("c_d2_vs_130", vs1, 0);
    adv_to(161);
    chk("c_d2_vs_161", vs1, 0);
    adv_to(162);
    chk("c_d2_vs_162", vs1, 1);
    adv_to(191);
    chk("c_fs_191", fs1, 0);
    chk("c_x_191", x1, 15);
    chk("c_y_191", y1, 11);
    adv_to(192);
    chk("c_fs_192", fs1, 1);
    chk("c_wrap_x", x1, 0);
    chk("c_wrap_y", y1, 0);
    chk("c_blank_0_0", b1, 1);
`ifdef VGA_FRAME_CNT_EN
    chk("c_fc", fc1, 1);
`endif
    adv_to(193);
    chk("c_fs_193", fs1, 0);
    chk("c_fs_count", fs1_cnt, 1);

    // Phase D: pix_ce alternating on the full-size instance
    do_reset(1'b0);
    moved = 0;
    lows = 0;
    first_x = -1;
    x_mid = '0;
    y_mid = '0;
    for (int i = 0; i < 1600; i++) begin
      pix_ce = (i % 2 == 0);
      prev_x = x0;
      step(1);
      if (!pix_ce && x0 != prev_x) moved++;
      if (!hs0) begin
        lows++;
        if (first_x < 0) first_x = int'(x0);
      end
      if (i == 1597) begin
        x_mid = x0;
        y_mid = y0;
      end
    end
    chk("d_no_move", moved, 0);
    chk("d_x_1598", x_mid, 799);
    chk("d_y_1598", y_mid, 0);
    chk("d_x_1600", x0, 0);
    chk("d_y_1600", y0, 1);
    chk("d_hs_fall_x", first_x, 658);
    chk("d_hs_low_clks", lows, 192);
    chk("d_no_fs", fs0_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal porch and sync widths in pixels. H_TOTAL = 800.
REQ-003 Parameter V_VISIBLE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical widths in lines. V_TOTAL = 525.
REQ-004 Parameter SYNC_DLY, 2, pipeline stages applied to hs/vs (range 0..4).
REQ-005 Port vga_clk, input, 1, pixel clock; all state on posedge.
REQ-006 Port reset, input, 1, asynchronous, active-high reset.
REQ-007 Port pix_ce, input, 1, pixel clock enable; counters advance only when 1.
REQ-008 Port DrawX, output, 10, current horizontal position (0..H_TOTAL-1).
REQ-009 Port DrawY, output, 10, current vertical position (0..V_TOTAL-1).
REQ-010 Port blank, output, 1, 1 = visible area (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanked.
REQ-011 Port hs, output, 1, horizontal sync, active-low, delayed by SYNC_DLY cycles.
REQ-012 Port vs, output, 1, vertical sync, active-low, delayed by SYNC_DLY cycles.
REQ-013 Port frame_start, output, 1, one-cycle pulse when the counters wrap to (0,0).
REQ-014 Port frame_count, output, 16, frame counter (present only with VGA_FRAME_CNT_EN).

Function
REQ-015 DrawX and DrawY shall be registered counters; blank shall be decoded combinationally from them, so it is aligned with DrawX/DrawY.
REQ-016 On a posedge with pix_ce=1, DrawX shall increment; at DrawX=H_TOTAL-1 it shall wrap to 0 and DrawY shall increment.
REQ-017 At DrawX=H_TOTAL-1 and DrawY=V_TOTAL-1, both counters shall wrap to 0 on the same edge.
REQ-018 With pix_ce=0, all counters and the sync pipeline shall hold; frame_start shall be 0.
REQ-019 Raw hs_n shall be 0 for DrawX in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656,751], else 1.
REQ-020 Raw vs_n shall be 0 for DrawY in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] = [490,491], else 1.
REQ-021 hs/vs shall equal raw hs_n/vs_n delayed by SYNC_DLY pix_ce-qualified stages. This matches the downstream ROM read and colour register latency. SYNC_DLY=0 shall be a direct combinational path.
REQ-022 frame_start shall be a registered output, 1 for exactly one vga_clk cycle following the edge that wraps the counters to (0,0).
REQ-023 All width arithmetic shall be 10-bit unsigned. Counters shall never exceed H_TOTAL-1 or V_TOTAL-1.

Reset
REQ-024 While reset=1: DrawX=0, DrawY=0, blank=1, hs=1, vs=1 (all pipeline stages =1), frame_start=0, frame_count=0.
REQ-025 Reset asserted mid-line or mid-frame shall return the block to (0,0) immediately. It shall not produce a frame_start pulse on release.
REQ-026 Counting shall resume on the first posedge with pix_ce=1 after reset deasserts.

Configuration
REQ-027 Macro VGA_FRAME_CNT_EN defined: frame_count shall increment (mod 2^16) on the same edge that frame_start is set.
REQ-028 Macro VGA_FRAME_CNT_EN undefined: the frame_count port and its register shall be absent. All other behaviour shall be identical.

Structure
REQ-029 Package vga_pkg shall hold the timing constants (H_/V_ defaults, H_TOTAL, V_TOTAL) and a typedef coord_t = logic [9:0].
REQ-030 Sub-module sync_delay shall implement the SYNC_DLY-stage, pix_ce-qualified, reset-to-1 shift pipeline. It shall be instantiated once for hs and once for vs.

Verification
REQ-031 Reset release, pix_ce=1 held -> DrawX=1 after 1 edge; DrawX=799→0 with DrawY=0→1 after 800 edges.
REQ-032 Run one full frame (420000 edges) -> frame_start pulses once; DrawX=0, DrawY=0; frame_count=1 with macro.
REQ-033 SYNC_DLY=2, count to DrawX=656 -> hs falls exactly 2 cycles later; hs low for 96 cycles; vs low for 2 lines from DrawY=490 (+2 cycles).
REQ-034 blank check -> blank=1 at (639,479), 0 at (640,0), 0 at (0,480), 1 at (0,0).
REQ-035 pix_ce toggling 1/0 each cycle -> line period of 1600 vga_clk cycles; hs delay 2 enabled cycles; no counter movement on pix_ce=0 cycles.
REQ-036 Reset pulsed at (700,300) -> outputs at reset values during reset; frame_start stays 0; normal count from (0,0) resumes afterwards.
